// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard bus: instruction operand info in, pipeline-register controls out.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int AW = 3
);
  logic          issue_valid;
  logic [AW-1:0] rs_id;
  logic [AW-1:0] rt_id;
  logic          rs_used;
  logic          rt_used;
  logic [AW-1:0] rd_id;
  logic          regwrite_id;
  logic          branch_taken;
  logic          mem_busy;
  logic          pc_we;
  logic          ifid_we;
  logic          ifid_flush;
  logic          idex_bubble;
  logic [7:0]    stall_cycles;
  logic          timeout_err;
  logic [1:0]    state;

  modport master (
    output issue_valid, rs_id, rt_id, rs_used, rt_used, rd_id, regwrite_id,
           branch_taken, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, stall_cycles, timeout_err, state
  );

  modport slave (
    input  issue_valid, rs_id, rt_id, rs_used, rt_used, rd_id, regwrite_id,
           branch_taken, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, stall_cycles, timeout_err, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: countdown scoreboard for in-flight
// register writes, memory-wait freeze with watchdog, and branch flush.
//
// state  | meaning
// RUN    | pipeline advances (also the branch-flush cycle)
// STALL  | RAW hazard in ID, bubble into ID/EX
// FREEZE | data memory busy, every stage holds
// ERROR  | memory wait timed out, pipeline halted until reset
module pipeline_hazard_ctrl #(
  parameter int NREG         = 8,
  parameter int AW           = 3,
  parameter int WB_DEPTH     = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_FREEZE = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     case_sel;
  logic [1:0] pending [NREG];
  logic [7:0] wait_cnt;
  logic [7:0] stall_cnt;
  logic       timeout_q;
  logic       rs_hit;
  logic       rt_hit;
  logic       hazard;
  logic       branch_sel;
  logic       fire;
  logic       sb_load;
  logic       timeout_hit;

  always_comb begin
    rs_hit = hz.rs_used && (hz.rs_id != '0) && (pending[hz.rs_id] != 2'd0);
    rt_hit = hz.rt_used && (hz.rt_id != '0) && (pending[hz.rt_id] != 2'd0);
    hazard = hz.issue_valid && (rs_hit || rt_hit);
  end

  // Case selection in priority order; the branch-flush cycle counts as RUN state
  // but never fires the ID instruction.
  always_comb begin
    case_sel   = S_RUN;
    branch_sel = 1'b0;
    if (state_q == S_ERROR) begin
      case_sel = S_ERROR;
    end else if (hz.mem_busy) begin
      case_sel = S_FREEZE;
    end else if (hz.branch_taken) begin
      case_sel   = S_RUN;
      branch_sel = 1'b1;
    end else if (hazard) begin
      case_sel = S_STALL;
    end
  end

  always_comb begin
    fire        = hz.issue_valid && (case_sel == S_RUN) && !branch_sel;
    sb_load     = fire && hz.regwrite_id && (hz.rd_id != '0);
    timeout_hit = (state_q != S_ERROR) && hz.mem_busy && (wait_cnt == 8'(MEM_WAIT_MAX));
  end

  // Zero-latency controls; reset forces a safe bubble regardless of state.
  always_comb begin
    hz.pc_we       = 1'b0;
    hz.ifid_we     = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b1;
    if (rst_n) begin
      case (case_sel)
        S_FREEZE: hz.idex_bubble = 1'b0;
        S_STALL:  hz.idex_bubble = 1'b1;
        S_RUN: begin
          hz.pc_we       = 1'b1;
          hz.ifid_we     = 1'b1;
          hz.ifid_flush  = branch_sel;
          hz.idex_bubble = branch_sel;
        end
        default: hz.idex_bubble = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= timeout_hit ? S_ERROR : case_sel;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (!hz.mem_busy) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((case_sel == S_STALL) && (stall_cnt != 8'hFF)) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end

  // Scoreboard: a fresh load on the same register wins over its decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        pending[i] <= 2'd0;
      end
    end else begin
      pending[0] <= 2'd0;
      if (!hz.mem_busy) begin
        for (int i = 1; i < NREG; i++) begin
          if (sb_load && (hz.rd_id == AW'(i))) begin
            pending[i] <= 2'(WB_DEPTH);
          end else if (pending[i] != 2'd0) begin
            pending[i] <= pending[i] - 2'd1;
          end
        end
      end
    end
  end

  assign hz.state        = state_q;
  assign hz.stall_cycles = stall_cnt;
  assign hz.timeout_err  = timeout_q;

endmodule
